tank_ctrl: RTL

//  Parametrised player-tank controller: grid movement, facing, shot request, hit detection, lives, respawn.

---
 rtl/tank_pkg.sv | 22 ++
 rtl/tank_hit_detect.sv | 26 ++
 rtl/tank_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
`default_nettype none
// ---- tank_pkg: facing encodings, FSM states and counter sizing for tank_ctrl (rev 1.0) ----
package tank_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_DEAD  = 2'd1,
    ST_OVER  = 2'd2
  } tank_state_t;

  // Width of a down-counter that must hold n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tank_hit_detect.sv
`default_nettype none
// ---- tank_hit_detect: any live enemy bullet sitting on the tank square (rev 1.0) ----
module tank_hit_detect #(
  parameter int COORD_W = 5,
  parameter int N_BUL   = 4
) (
  input  logic [N_BUL*COORD_W-1:0] bul_x,
  input  logic [N_BUL*COORD_W-1:0] bul_y,
  input  logic [N_BUL-1:0]         bul_vld,
  input  logic [COORD_W-1:0]       pos_x,
  input  logic [COORD_W-1:0]       pos_y,
  output logic                     hit
);

  logic [N_BUL-1:0] match;

  for (genvar i = 0; i < N_BUL; i++) begin : g_cmp
    assign match[i] = bul_vld[i]
                   && (bul_x[i*COORD_W +: COORD_W] == pos_x)
                   && (bul_y[i*COORD_W +: COORD_W] == pos_y);
  end

  assign hit = |match;

endmodule
`default_nettype wire

// File: rtl/tank_ctrl.sv
`default_nettype none
// ---- tank_ctrl: player tank movement, facing, shooting, hits, lives and respawn (rev 1.0) ----
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int COORD_W       = 5,
  parameter int X_MAX         = 16,
  parameter int Y_MAX         = 20,
  parameter int N_BUL         = 4,
  parameter int INIT_X        = 7,
  parameter int INIT_Y        = 7,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 8,
  parameter int SHOT_CD       = 2,
  localparam int LW           = $clog2(LIVES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     tank_en,
  input  logic                     bt_w,
  input  logic                     bt_a,
  input  logic                     bt_s,
  input  logic                     bt_d,
  input  logic                     bt_st,
  input  logic [N_BUL*COORD_W-1:0] bul_x,
  input  logic [N_BUL*COORD_W-1:0] bul_y,
  input  logic [N_BUL-1:0]         bul_vld,
  input  logic                     mybul_busy,
  output logic [COORD_W-1:0]       pos_x,
  output logic [COORD_W-1:0]       pos_y,
  output logic [1:0]               dir,
  output logic                     alive,
  output logic [LW-1:0]            lives_left,
  output logic                     bul_sht,
  output logic                     hit_pulse,
  output logic                     game_over
);

  localparam int RW = cnt_w(RESPAWN_TICKS);
  localparam int CW = cnt_w(SHOT_CD);

  localparam logic [COORD_W-1:0] X_LIM   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM   = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] X_SPAWN = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] Y_SPAWN = COORD_W'(INIT_Y);
  localparam logic [LW-1:0]      LIVES_C = LW'(LIVES);
  localparam logic [RW-1:0]      RESP_C  = RW'(RESPAWN_TICKS);
  localparam logic [CW-1:0]      CD_C    = CW'(SHOT_CD);

  tank_state_t          state;
  tank_state_t          state_nx;
  logic [COORD_W-1:0]   x_nx;
  logic [COORD_W-1:0]   y_nx;
  logic [1:0]           dir_nx;
  logic [LW-1:0]        lives_nx;
  logic [RW-1:0]        resp_cnt;
  logic [RW-1:0]        resp_nx;
  logic [CW-1:0]        cd_cnt;
  logic [CW-1:0]        cd_nx;
  logic                 sht_nx;
  logic                 hitp_nx;
  logic                 hit;
  logic                 can_shoot;

  tank_hit_detect #(
    .COORD_W (COORD_W),
    .N_BUL   (N_BUL)
  ) u_hit (
    .bul_x   (bul_x),
    .bul_y   (bul_y),
    .bul_vld (bul_vld),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .hit     (hit)
  );

  assign alive     = (state == ST_ALIVE);
  assign game_over = (state == ST_OVER);
  assign can_shoot = bt_st && !mybul_busy && (cd_cnt == '0) && !bul_sht;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ALIVE;
      pos_x      <= X_SPAWN;
      pos_y      <= Y_SPAWN;
      dir        <= DIR_UP;
      lives_left <= LIVES_C;
      resp_cnt   <= '0;
      cd_cnt     <= '0;
      bul_sht    <= 1'b0;
      hit_pulse  <= 1'b0;
    end else begin
      state      <= state_nx;
      pos_x      <= x_nx;
      pos_y      <= y_nx;
      dir        <= dir_nx;
      lives_left <= lives_nx;
      resp_cnt   <= resp_nx;
      cd_cnt     <= cd_nx;
      bul_sht    <= sht_nx;
      hit_pulse  <= hitp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x_nx     = pos_x;
    y_nx     = pos_y;
    dir_nx   = dir;
    lives_nx = lives_left;
    resp_nx  = resp_cnt;
    cd_nx    = cd_cnt;
    sht_nx   = 1'b0;
    hitp_nx  = 1'b0;

    if (tick && (cd_cnt != '0)) begin
      cd_nx = cd_cnt - 1'b1;
    end

    case (state)
      ST_ALIVE: begin
        // A hit pre-empts both the move and the shot of this cycle.
        if (hit) begin
          hitp_nx  = 1'b1;
          lives_nx = lives_left - 1'b1;
          if (lives_left == LW'(1)) begin
            state_nx = ST_OVER;
          end else begin
            state_nx = ST_DEAD;
            resp_nx  = RESP_C;
          end
        end else if (tank_en) begin
          if (tick) begin
            if (bt_w) begin
              dir_nx = DIR_UP;
              if (pos_y != '0) y_nx = pos_y - 1'b1;
            end else if (bt_s) begin
              dir_nx = DIR_DOWN;
              if (pos_y != Y_LIM) y_nx = pos_y + 1'b1;
            end else if (bt_a) begin
              dir_nx = DIR_LEFT;
              if (pos_x != '0) x_nx = pos_x - 1'b1;
            end else if (bt_d) begin
              dir_nx = DIR_RIGHT;
              if (pos_x != X_LIM) x_nx = pos_x + 1'b1;
            end
          end
          if (can_shoot) begin
            sht_nx = 1'b1;
            cd_nx  = CD_C;
          end
        end
      end
      ST_DEAD: begin
        if (tick) begin
          if (resp_cnt <= RW'(1)) begin
            state_nx = ST_ALIVE;
            x_nx     = X_SPAWN;
            y_nx     = Y_SPAWN;
            dir_nx   = DIR_UP;
            resp_nx  = '0;
          end else begin
            resp_nx = resp_cnt - 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire
